// File: rtl/ab_compare_monitor.sv
`default_nettype none
// ============================================================================
// ab_compare_monitor : classifies a/b sample pairs and keeps saturating counts
// over a fixed-length run.
// Optional sequence checker enabled by macro ABCMP_SEQ_CHECK_EN.
// Rev 1.0
// ============================================================================
module ab_compare_monitor #(
  parameter int DATA_W      = 4,
  parameter int CNT_W       = 16,
  parameter int MAX_SAMPLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  eq_cnt,
  output logic [DATA_W-1:0] last_eq_val,
  output logic              seq_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_max_samples = CNT_W'(MAX_SAMPLES);

  state_t             r_state;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_pass;
  logic [CNT_W-1:0]   r_fail;
  logic [CNT_W-1:0]   r_eq;
  logic [CNT_W-1:0]   r_sample_cnt;
  logic [DATA_W-1:0]  r_last_eq;

  logic w_accept;
  logic w_start;
  logic w_last;

  assign w_accept = in_valid & r_in_ready;
  assign w_start  = start & (r_state != S_RUN);
  assign w_last   = w_accept && ((r_sample_cnt + CNT_W'(1)) == c_max_samples);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == c_cnt_max) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= '0;
      r_fail       <= '0;
      r_eq         <= '0;
      r_sample_cnt <= '0;
      r_last_eq    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state      <= S_RUN;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= '0;
            r_fail       <= '0;
            r_eq         <= '0;
            r_sample_cnt <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            if (in_a > in_b) r_pass <= sat_inc(r_pass);
            else             r_fail <= sat_inc(r_fail);
            if (in_a == in_b) begin
              r_eq      <= sat_inc(r_eq);
              r_last_eq <= in_a;
            end
            if (w_last) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

`ifdef ABCMP_SEQ_CHECK_EN
  // First accept of a run only seeds the reference; later accepts must step by +1.
  logic              r_have_ref;
  logic [DATA_W-1:0] r_prev_a;
  logic [DATA_W-1:0] r_prev_b;
  logic              r_seq_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_have_ref <= 1'b0;
      r_prev_a   <= '0;
      r_prev_b   <= '0;
      r_seq_err  <= 1'b0;
    end else if (w_start) begin
      r_have_ref <= 1'b0;
      r_seq_err  <= 1'b0;
    end else if (w_accept) begin
      r_have_ref <= 1'b1;
      r_prev_a   <= in_a;
      r_prev_b   <= in_b;
      if (r_have_ref &&
          ((in_a != r_prev_a + DATA_W'(1)) || (in_b != r_prev_b + DATA_W'(1))))
        r_seq_err <= 1'b1;
    end
  end

  assign seq_err = r_seq_err;
`else
  assign seq_err = 1'b0;
`endif

  assign in_ready    = r_in_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass_cnt    = r_pass;
  assign fail_cnt    = r_fail;
  assign eq_cnt      = r_eq;
  assign last_eq_val = r_last_eq;

endmodule
`default_nettype wire

// File: tb/tb_ab_compare_monitor.sv
`default_nettype none
// ============================================================================
// tb_ab_compare_monitor : directed stimulus against two monitor instances
// (default widths, and a 2-bit-counter variant) checked by a run-level model.
// Rev 1.0
// ============================================================================
module tb_ab_compare_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b1;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;

  logic        d_rdy, d_busy, d_done, d_seq;
  logic [15:0] d_pass, d_fail, d_eq;
  logic [3:0]  d_last;
  logic        s_rdy, s_busy, s_done, s_seq;
  logic [1:0]  s_pass, s_fail, s_eq;
  logic [3:0]  s_last;

  int checks = 0;
  int errors = 0;
  bit model_live = 1'b0;

  always #5 clk = ~clk;

  ab_compare_monitor #(.DATA_W(4), .CNT_W(16), .MAX_SAMPLES(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(d_rdy),
    .in_a(in_a), .in_b(in_b), .busy(d_busy), .done(d_done),
    .pass_cnt(d_pass), .fail_cnt(d_fail), .eq_cnt(d_eq),
    .last_eq_val(d_last), .seq_err(d_seq)
  );

  ab_compare_monitor #(.DATA_W(4), .CNT_W(2), .MAX_SAMPLES(3)) u_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_rdy),
    .in_a(in_a), .in_b(in_b), .busy(s_busy), .done(s_done),
    .pass_cnt(s_pass), .fail_cnt(s_fail), .eq_cnt(s_eq),
    .last_eq_val(s_last), .seq_err(s_seq)
  );

  // Run-level model: phase 0=idle, 1=run, 2=done; counts as plain integers.
  int m_max[2]  = '{4, 3};
  int m_cmax[2] = '{65535, 3};
  int m_phase[2], m_n[2], m_pass[2], m_fail[2], m_eq[2], m_last[2];
  int m_seq[2], m_have[2], m_pa[2], m_pb[2];

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_phase[d] = 0; m_n[d] = 0; m_pass[d] = 0; m_fail[d] = 0; m_eq[d] = 0;
        m_last[d] = 0; m_seq[d] = 0; m_have[d] = 0;
      end else if (m_phase[d] != 1) begin
        if (start) begin
          m_phase[d] = 1; m_n[d] = 0; m_pass[d] = 0; m_fail[d] = 0; m_eq[d] = 0;
          m_seq[d] = 0; m_have[d] = 0;
        end
      end else if (in_valid) begin
        m_n[d]++;
        if (int'(in_a) > int'(in_b)) m_pass[d] = sat(m_pass[d] + 1, m_cmax[d]);
        else                         m_fail[d] = sat(m_fail[d] + 1, m_cmax[d]);
        if (in_a == in_b) begin
          m_eq[d] = sat(m_eq[d] + 1, m_cmax[d]);
          m_last[d] = int'(in_a);
        end
        if (m_have[d] != 0 &&
            (int'(in_a) != (m_pa[d] + 1) % 16 || int'(in_b) != (m_pb[d] + 1) % 16))
          m_seq[d] = 1;
        m_have[d] = 1; m_pa[d] = int'(in_a); m_pb[d] = int'(in_b);
        if (m_n[d] == m_max[d]) m_phase[d] = 2;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int d, input string tag, input logic rdy, input logic bsy,
                         input logic dn, input logic [31:0] ps, input logic [31:0] fl,
                         input logic [31:0] eq, input logic [31:0] lst, input logic sq);
    int exp_seq;
`ifdef ABCMP_SEQ_CHECK_EN
    exp_seq = m_seq[d];
`else
    exp_seq = 0;
`endif
    chk({tag, ".in_ready"}, 32'(rdy), 32'(m_phase[d] == 1));
    chk({tag, ".busy"},     32'(bsy), 32'(m_phase[d] == 1));
    chk({tag, ".done"},     32'(dn),  32'(m_phase[d] == 2));
    chk({tag, ".pass_cnt"}, ps,  32'(m_pass[d]));
    chk({tag, ".fail_cnt"}, fl,  32'(m_fail[d]));
    chk({tag, ".eq_cnt"},   eq,  32'(m_eq[d]));
    chk({tag, ".last_eq"},  lst, 32'(m_last[d]));
    chk({tag, ".seq_err"},  32'(sq), 32'(exp_seq));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_n[d] = 0; m_pass[d] = 0; m_fail[d] = 0; m_eq[d] = 0;
      m_last[d] = 0; m_seq[d] = 0; m_have[d] = 0; m_pa[d] = 0; m_pb[d] = 0;
    end
    forever begin
      @(posedge clk);
      model_step();
      model_live = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        cmp_dut(0, "dut", d_rdy, d_busy, d_done, 32'(d_pass), 32'(d_fail), 32'(d_eq),
                32'(d_last), d_seq);
        cmp_dut(1, "sat", s_rdy, s_busy, s_done, 32'(s_pass), 32'(s_fail), 32'(s_eq),
                32'(s_last), s_seq);
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic v,
                      input logic [3:0] a, input logic [3:0] b);
    @(posedge clk);
    #1;
    rst = r; start = s; in_valid = v; in_a = a; in_b = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    // T1: reset held with in_valid high, then in_valid high while idle
    step(1'b1, 1'b0, 1'b1, 4'd3, 4'd1);
    step(1'b0, 1'b0, 1'b1, 4'd3, 4'd1);
    @(negedge clk);
    chk("t1.pass_cnt", 32'(d_pass), 32'd0);
    chk("t1.in_ready", 32'(d_rdy), 32'd0);
    chk("t1.done", 32'(d_done), 32'd0);
    idle(1);

    // T2: four mixed pairs
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd5, 4'd3);
    step(1'b0, 1'b0, 1'b1, 4'd2, 4'd7);
    step(1'b0, 1'b0, 1'b1, 4'd6, 4'd6);
    step(1'b0, 1'b0, 1'b1, 4'd9, 4'd1);
    idle(1);
    @(negedge clk);
    chk("t2.pass_cnt", 32'(d_pass), 32'd2);
    chk("t2.fail_cnt", 32'(d_fail), 32'd2);
    chk("t2.eq_cnt", 32'(d_eq), 32'd1);
    chk("t2.last_eq", 32'(d_last), 32'd6);
    chk("t2.done", 32'(d_done), 32'd1);

    // T3: valid every other cycle, then valid held in DONE
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd1, 4'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
    step(1'b0, 1'b0, 1'b1, 4'd2, 4'd1);
    step(1'b0, 1'b0, 1'b0, 4'd9, 4'd9);
    step(1'b0, 1'b0, 1'b1, 4'd3, 4'd3);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd4, 4'd5);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'd8, 4'd8);
    @(negedge clk);
    chk("t3.in_ready", 32'(d_rdy), 32'd0);
    chk("t3.eq_cnt", 32'(d_eq), 32'd1);
    chk("t3.last_eq", 32'(d_last), 32'd3);

    // T4: reset after two accepts, rst+start together, then a clean run
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd7, 4'd2);
    step(1'b0, 1'b0, 1'b1, 4'd1, 4'd2);
    step(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    chk("t4.pass_cnt", 32'(d_pass), 32'd0);
    chk("t4.busy", 32'(d_busy), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd2, 4'd2);
    step(1'b0, 1'b0, 1'b1, 4'd3, 4'd1);
    step(1'b0, 1'b1, 1'b1, 4'd0, 4'd4);
    step(1'b0, 1'b0, 1'b1, 4'd5, 4'd5);
    idle(1);
    @(negedge clk);
    chk("t4.fail_cnt", 32'(d_fail), 32'd3);
    chk("t4.done", 32'(d_done), 32'd1);

    // T5: all a>b, 2-bit counters, two back-to-back runs
    for (int r = 0; r < 2; r++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'd15, 4'(i));
      idle(1);
      @(negedge clk);
      chk("t5.sat_pass", 32'(s_pass), 32'd3);
      chk("t5.dut_pass", 32'(d_pass), 32'd4);
    end

    // T6: a=0,1,2,4 b=0,1,2,3 breaks the +1 sequence on the fourth accept
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, (i == 3) ? 4'd4 : 4'(i), 4'(i));
    idle(1);
    @(negedge clk);
`ifdef ABCMP_SEQ_CHECK_EN
    chk("t6.seq_err", 32'(d_seq), 32'd1);
`else
    chk("t6.seq_err", 32'(d_seq), 32'd0);
`endif
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    idle(1);
    @(negedge clk);
    chk("t6.seq_clr", 32'(d_seq), 32'd0);
    // Wrap 14,15,0 is a legal sequence
    step(1'b0, 1'b0, 1'b1, 4'd14, 4'd14);
    step(1'b0, 1'b0, 1'b1, 4'd15, 4'd15);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    idle(2);
    @(negedge clk);
    chk("t6.wrap_seq", 32'(d_seq), 32'd0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
